ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipe_pkg.sv | 10 +
 rtl/ctrl_pipeline_hazard_detect.sv | 78 +++++++
 rtl/ctrl_pipeline.sv | 147 ++++++++++++++
 tb/tb_ctrl_pipeline.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared widths and forward-select encodings for the control pipeline.
// Forwarding build is selected with the CTRL_PIPE_FWD_EN macro.
package ctrl_pipe_pkg;
  localparam int REG_AW_DEFAULT = 5;
  localparam int ALUC_W_DEFAULT = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/ctrl_pipeline_hazard_detect.sv
// Combinational stall and forward-select logic for the D/E operands.
// CTRL_PIPE_FWD_EN defined: bypass network; undefined: interlock-only stalls.
module hazard_detect
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeRegE,
  input  logic              regWriteE,
  input  logic              memtoRegE,
  input  logic [REG_AW-1:0] writeRegM,
  input  logic              regWriteM,
  input  logic              memtoRegM,
  input  logic [REG_AW-1:0] writeRegW,
  input  logic              regWriteW,
  output logic              stall,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD
);

  // $0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic [REG_AW-1:0] srcD [2];
  logic [3:0]        fwdE;
  logic [1:0]        fwdD;
  logic [1:0]        hazHit;

  assign srcD[0] = rsD;
  assign srcD[1] = rtD;

`ifdef CTRL_PIPE_FWD_EN
  logic [REG_AW-1:0] srcE [2];
  assign srcE[0] = rsE;
  assign srcE[1] = rtE;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSrc
`ifdef CTRL_PIPE_FWD_EN
      assign fwdE[2*gi +: 2] = (regWriteM && hit(writeRegM, srcE[gi])) ? FWD_MEM :
                               (regWriteW && hit(writeRegW, srcE[gi])) ? FWD_WB  : FWD_RF;
      assign fwdD[gi]   = regWriteM && hit(writeRegM, srcD[gi]);
      assign hazHit[gi] = (memtoRegE && hit(rtE, srcD[gi])) ||
                          (branchD && ((regWriteE && hit(writeRegE, srcD[gi])) ||
                                       (memtoRegM && hit(writeRegM, srcD[gi]))));
`else
      assign fwdE[2*gi +: 2] = FWD_RF;
      assign fwdD[gi]   = 1'b0;
      assign hazHit[gi] = (regWriteE && hit(writeRegE, srcD[gi])) ||
                          (regWriteM && hit(writeRegM, srcD[gi]));
`endif
    end
  endgenerate

`ifndef CTRL_PIPE_FWD_EN
  // WB needs no interlock: the register file writes before it reads.
  logic unusedNoFwd;
  assign unusedNoFwd = ^{branchD, rsE, rtE, memtoRegE, memtoRegM, writeRegW, regWriteW};
`endif

  assign stall     = |hazHit;
  assign forwardAE = fwdE[1:0];
  assign forwardBE = fwdE[3:2];
  assign forwardAD = fwdD[0];
  assign forwardBD = fwdD[1];

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-side D->E->M->W stage registers with hazard/forwarding selects.
// Define CTRL_PIPE_FWD_EN for the forwarding build; default is interlock-only.
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int ALUC_W = ALUC_W_DEFAULT
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_RegWriteD,
  input  logic              i_MemtoRegD,
  input  logic              i_MemWriteD,
  input  logic              i_ALUSrcD,
  input  logic              i_RegDstD,
  input  logic              i_BranchD,
  input  logic [ALUC_W-1:0] i_ALUControlD,
  input  logic [REG_AW-1:0] i_RsD,
  input  logic [REG_AW-1:0] i_RtD,
  input  logic [REG_AW-1:0] i_RdD,
  output logic              o_RegWriteE,
  output logic              o_MemtoRegE,
  output logic              o_MemWriteE,
  output logic              o_ALUSrcE,
  output logic [ALUC_W-1:0] o_ALUControlE,
  output logic [REG_AW-1:0] o_RsE,
  output logic [REG_AW-1:0] o_RtE,
  output logic [REG_AW-1:0] o_WriteRegE,
  output logic              o_RegWriteM,
  output logic              o_MemtoRegM,
  output logic              o_MemWriteM,
  output logic [REG_AW-1:0] o_WriteRegM,
  output logic              o_RegWriteW,
  output logic              o_MemtoRegW,
  output logic [REG_AW-1:0] o_WriteRegW,
  output logic              o_StallF,
  output logic              o_StallD,
  output logic              o_FlushE,
  output logic [1:0]        o_ForwardAE,
  output logic [1:0]        o_ForwardBE,
  output logic              o_ForwardAD,
  output logic              o_ForwardBD
);

  logic              regWriteE, memtoRegE, memWriteE, aluSrcE, regDstE;
  logic [ALUC_W-1:0] aluControlE;
  logic [REG_AW-1:0] rsE, rtE, rdE, writeRegE;
  logic              regWriteM, memtoRegM, memWriteM;
  logic [REG_AW-1:0] writeRegM;
  logic              regWriteW, memtoRegW;
  logic [REG_AW-1:0] writeRegW;
  logic              stall;

  assign writeRegE = regDstE ? rdE : rtE;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      regWriteE   <= 1'b0;
      memtoRegE   <= 1'b0;
      memWriteE   <= 1'b0;
      aluSrcE     <= 1'b0;
      regDstE     <= 1'b0;
      aluControlE <= '0;
      rsE         <= '0;
      rtE         <= '0;
      rdE         <= '0;
      regWriteM   <= 1'b0;
      memtoRegM   <= 1'b0;
      memWriteM   <= 1'b0;
      writeRegM   <= '0;
      regWriteW   <= 1'b0;
      memtoRegW   <= 1'b0;
      writeRegW   <= '0;
    end else begin
      // A stalled decode slot turns into a bubble in EX; later stages drain.
      if (stall) begin
        regWriteE   <= 1'b0;
        memtoRegE   <= 1'b0;
        memWriteE   <= 1'b0;
        aluSrcE     <= 1'b0;
        regDstE     <= 1'b0;
        aluControlE <= '0;
        rsE         <= '0;
        rtE         <= '0;
        rdE         <= '0;
      end else begin
        regWriteE   <= i_RegWriteD;
        memtoRegE   <= i_MemtoRegD;
        memWriteE   <= i_MemWriteD;
        aluSrcE     <= i_ALUSrcD;
        regDstE     <= i_RegDstD;
        aluControlE <= i_ALUControlD;
        rsE         <= i_RsD;
        rtE         <= i_RtD;
        rdE         <= i_RdD;
      end
      regWriteM <= regWriteE;
      memtoRegM <= memtoRegE;
      memWriteM <= memWriteE;
      writeRegM <= writeRegE;
      regWriteW <= regWriteM;
      memtoRegW <= memtoRegM;
      writeRegW <= writeRegM;
    end
  end

  hazard_detect #(.REG_AW(REG_AW)) uHazard (
    .rsD       (i_RsD),
    .rtD       (i_RtD),
    .branchD   (i_BranchD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeRegE (writeRegE),
    .regWriteE (regWriteE),
    .memtoRegE (memtoRegE),
    .writeRegM (writeRegM),
    .regWriteM (regWriteM),
    .memtoRegM (memtoRegM),
    .writeRegW (writeRegW),
    .regWriteW (regWriteW),
    .stall     (stall),
    .forwardAE (o_ForwardAE),
    .forwardBE (o_ForwardBE),
    .forwardAD (o_ForwardAD),
    .forwardBD (o_ForwardBD)
  );

  assign o_RegWriteE   = regWriteE;
  assign o_MemtoRegE   = memtoRegE;
  assign o_MemWriteE   = memWriteE;
  assign o_ALUSrcE     = aluSrcE;
  assign o_ALUControlE = aluControlE;
  assign o_RsE         = rsE;
  assign o_RtE         = rtE;
  assign o_WriteRegE   = writeRegE;
  assign o_RegWriteM   = regWriteM;
  assign o_MemtoRegM   = memtoRegM;
  assign o_MemWriteM   = memWriteM;
  assign o_WriteRegM   = writeRegM;
  assign o_RegWriteW   = regWriteW;
  assign o_MemtoRegW   = memtoRegW;
  assign o_WriteRegW   = writeRegW;
  assign o_StallF      = stall;
  assign o_StallD      = stall;
  assign o_FlushE      = stall;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline; expectations follow the CTRL_PIPE_FWD_EN
// setting the bench is compiled with (default: interlock-only build).
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       rw, mtr, mw, as, regDst, br;
    logic [2:0] aluc;
    logic [4:0] rs, rt, rd;
  } instr_t;

  localparam instr_t NOP = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       regWriteD, memtoRegD, memWriteD, aluSrcD, regDstD, branchD;
  logic [2:0] aluControlD;
  logic [4:0] rsD, rtD, rdD;

  logic       regWriteE, memtoRegE, memWriteE, aluSrcE;
  logic [2:0] aluControlE;
  logic [4:0] rsE, rtE, writeRegE;
  logic       regWriteM, memtoRegM, memWriteM;
  logic [4:0] writeRegM;
  logic       regWriteW, memtoRegW;
  logic [4:0] writeRegW;
  logic       stallF, stallD, flushE;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD;

  ctrl_pipeline dut (
    .i_CLK(clk), .i_RST(rst),
    .i_RegWriteD(regWriteD), .i_MemtoRegD(memtoRegD), .i_MemWriteD(memWriteD),
    .i_ALUSrcD(aluSrcD), .i_RegDstD(regDstD), .i_BranchD(branchD),
    .i_ALUControlD(aluControlD), .i_RsD(rsD), .i_RtD(rtD), .i_RdD(rdD),
    .o_RegWriteE(regWriteE), .o_MemtoRegE(memtoRegE), .o_MemWriteE(memWriteE),
    .o_ALUSrcE(aluSrcE), .o_ALUControlE(aluControlE), .o_RsE(rsE), .o_RtE(rtE),
    .o_WriteRegE(writeRegE),
    .o_RegWriteM(regWriteM), .o_MemtoRegM(memtoRegM), .o_MemWriteM(memWriteM),
    .o_WriteRegM(writeRegM),
    .o_RegWriteW(regWriteW), .o_MemtoRegW(memtoRegW), .o_WriteRegW(writeRegW),
    .o_StallF(stallF), .o_StallD(stallD), .o_FlushE(flushE),
    .o_ForwardAE(forwardAE), .o_ForwardBE(forwardBE),
    .o_ForwardAD(forwardAD), .o_ForwardBD(forwardBD)
  );

  wire [13:0] hazOut = {stallF, stallD, flushE, forwardAE, forwardBE, forwardAD, forwardBD, writeRegE};
  wire [21:0] eOut   = {regWriteE, memtoRegE, memWriteE, aluSrcE, aluControlE, rsE, rtE, writeRegE};
  wire [7:0]  mOut   = {regWriteM, memtoRegM, memWriteM, writeRegM};
  wire [6:0]  wOut   = {regWriteW, memtoRegW, writeRegW};
  wire [45:0] allOut = {eOut, mOut, wOut, stallF, stallD, flushE, forwardAE, forwardBE, forwardAD, forwardBD};

  int compared = 0;
  int mismatched = 0;
  instr_t     dQ[$];
  logic [13:0] eQ[$];

  function automatic instr_t mkAdd(input int d, input int s, input int t);
    instr_t i = '0;
    i.rw = 1'b1; i.regDst = 1'b1; i.aluc = 3'd2;
    i.rs = s[4:0]; i.rt = t[4:0]; i.rd = d[4:0];
    return i;
  endfunction

  function automatic instr_t mkLw(input int t, input int s);
    instr_t i = '0;
    i.rw = 1'b1; i.mtr = 1'b1; i.as = 1'b1; i.aluc = 3'd2;
    i.rs = s[4:0]; i.rt = t[4:0];
    return i;
  endfunction

  function automatic instr_t mkBeq(input int s, input int t);
    instr_t i = '0;
    i.br = 1'b1; i.aluc = 3'd6;
    i.rs = s[4:0]; i.rt = t[4:0];
    return i;
  endfunction

  // Expected {stall x3, ForwardAE, ForwardBE, ForwardAD, ForwardBD, WriteRegE}.
  function automatic logic [13:0] ev(input logic s, input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic fad, input logic fbd, input logic [4:0] wr);
    return {s, s, s, fae, fbe, fad, fbd, wr};
  endfunction

  task automatic setD(input instr_t i);
    regWriteD = i.rw; memtoRegD = i.mtr; memWriteD = i.mw; aluSrcD = i.as;
    regDstD = i.regDst; branchD = i.br; aluControlD = i.aluc;
    rsD = i.rs; rtD = i.rt; rdD = i.rd;
  endtask

  task automatic row(input instr_t d, input logic [13:0] e);
    dQ.push_back(d);
    eQ.push_back(e);
  endtask

  task automatic drain();
    setD(NOP);
    repeat (4) @(posedge clk);
    #1;
    dQ.delete();
    eQ.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setD(mkAdd(3, 1, 2));
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    compared++;
    $display("reset: outputs=%h", allOut);
    if (allOut !== '0) begin
      mismatched++;
      $display("FAIL reset_clear: got %h want 0", allOut);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    instr_t x, y;
    x = '{rw: 1'b1, mtr: 1'b1, mw: 1'b1, as: 1'b1, regDst: 1'b0, br: 1'b0,
          aluc: 3'd5, rs: 5'd7, rt: 5'd9, rd: 5'd12};
    y = '{rw: 1'b1, mtr: 1'b0, mw: 1'b0, as: 1'b0, regDst: 1'b1, br: 1'b0,
          aluc: 3'd2, rs: 5'd10, rt: 5'd11, rd: 5'd12};
    drain();
    setD(x);
    @(posedge clk); #1; setD(y);
    @(negedge clk);
    compared++;
    $display("latency: E=%h", eOut);
    if (eOut !== {4'b1111, 3'd5, 5'd7, 5'd9, 5'd9}) begin
      mismatched++; $display("FAIL latency_E_x: got %h", eOut);
    end
    @(posedge clk); #1; setD(NOP);
    @(negedge clk);
    compared += 2;
    $display("latency: E=%h M=%h", eOut, mOut);
    if (mOut !== {3'b111, 5'd9}) begin
      mismatched++; $display("FAIL latency_M_x: got %h want %h", mOut, {3'b111, 5'd9});
    end
    if (eOut !== {4'b1000, 3'd2, 5'd10, 5'd11, 5'd12}) begin
      mismatched++; $display("FAIL latency_E_y_rd: got %h", eOut);
    end
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    $display("latency: W=%h", wOut);
    if (wOut !== {2'b11, 5'd9}) begin
      mismatched++; $display("FAIL latency_W_x: got %h want %h", wOut, {2'b11, 5'd9});
    end
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    $display("latency: W=%h", wOut);
    if (wOut !== {2'b10, 5'd12}) begin
      mismatched++; $display("FAIL latency_W_y: got %h want %h", wOut, {2'b10, 5'd12});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_fwd();
    instr_t a, b;
    a = mkAdd(3, 1, 2);
    b = mkAdd(5, 3, 4);
    drain();
`ifdef CTRL_PIPE_FWD_EN
    row(a,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(b,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3));
    row(NOP, ev(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 5'd5));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(a,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3));
    row(b,   ev(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd5));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
`else
    row(a,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(b,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3));
    row(b,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(b,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd5));
    row(a,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3));
    row(b,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(b,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd5));
`endif
    for (int i = 0; i < dQ.size(); i++) begin
      setD(dQ[i]);
      @(negedge clk);
      compared++;
      $display("alu_fwd c%0d: haz=%b", i, hazOut);
      if (hazOut !== eQ[i]) begin
        mismatched++; $display("FAIL alu_fwd c%0d: got %b want %b", i, hazOut, eQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    instr_t l, c;
    l = mkLw(5, 1);
    c = mkAdd(6, 5, 2);
    drain();
`ifdef CTRL_PIPE_FWD_EN
    row(l,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(c,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd5));
    row(c,   ev(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd6));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
`else
    row(l,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(c,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd5));
    row(c,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(c,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd6));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
`endif
    for (int i = 0; i < dQ.size(); i++) begin
      setD(dQ[i]);
      @(negedge clk);
      compared++;
      $display("load_use c%0d: haz=%b", i, hazOut);
      if (hazOut !== eQ[i]) begin
        mismatched++; $display("FAIL load_use c%0d: got %b want %b", i, hazOut, eQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    instr_t a4, q, l4;
    a4 = mkAdd(4, 1, 2);
    q  = mkBeq(4, 7);
    l4 = mkLw(4, 1);
    drain();
`ifdef CTRL_PIPE_FWD_EN
    row(a4,  ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd4));
    row(q,   ev(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd7));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(l4,  ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd4));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0));
    row(q,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd7));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
`else
    row(a4,  ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd4));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(q,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd7));
    row(l4,  ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd4));
    row(q,   ev(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(q,   ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd7));
    row(NOP, ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
`endif
    for (int i = 0; i < dQ.size(); i++) begin
      setD(dQ[i]);
      @(negedge clk);
      compared++;
      $display("branch c%0d: haz=%b", i, hazOut);
      if (hazOut !== eQ[i]) begin
        mismatched++; $display("FAIL branch c%0d: got %b want %b", i, hazOut, eQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    drain();
    row(mkAdd(0, 1, 2), ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(mkAdd(6, 0, 0), ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(mkLw(0, 1),     ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd6));
    row(mkAdd(6, 0, 0), ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(mkBeq(0, 0),    ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd6));
    row(NOP,            ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    row(NOP,            ev(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0));
    for (int i = 0; i < dQ.size(); i++) begin
      setD(dQ[i]);
      @(negedge clk);
      compared++;
      $display("zero_reg c%0d: haz=%b", i, hazOut);
      if (hazOut !== eQ[i]) begin
        mismatched++; $display("FAIL zero_reg c%0d: got %b want %b", i, hazOut, eQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_stall();
    drain();
    setD(mkLw(5, 1));
    @(posedge clk); #1;
    setD(mkAdd(6, 5, 2));
    @(negedge clk);
    compared++;
    $display("rst_stall: stall=%b%b%b", stallF, stallD, flushE);
    if ({stallF, stallD, flushE} !== 3'b111) begin
      mismatched++; $display("FAIL rst_stall_pre: got %b want 111", {stallF, stallD, flushE});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    $display("rst_stall: outputs=%h", allOut);
    if (allOut !== '0) begin
      mismatched++; $display("FAIL rst_stall_clear: got %h want 0", allOut);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d compared", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    setD(NOP);
    test_reset();
    test_latency();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_reset_in_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
